// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a ready/valid byte input and a registered, idle-high line.
// Define UART_PARITY_EN to insert one even parity bit between the data bits and the stop bit.
module uart_transmitter #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SYMBOL_EDGE_TIME - 1);
    // Ready is registered, so it is raised one cycle ahead of the final stop cycle.
    localparam logic [CNT_W-1:0] CNT_READY = CNT_W'(SYMBOL_EDGE_TIME - 2);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] value);
        return ^value;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
`ifdef UART_PARITY_EN
    logic             parity_r;
`endif
    logic             accept_s;
    logic             bit_wrap_s;

    assign accept_s   = data_in_valid & data_in_ready;
    assign bit_wrap_s = (cnt_r == CNT_LAST);

    // Frame sequencer: bit timing, shifting and the registered line/ready outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            serial_out    <= 1'b1;
            data_in_ready <= 1'b1;
            cnt_r         <= CNT_ZERO;
            bit_idx_r     <= 3'd0;
            shift_r       <= 8'h00;
`ifdef UART_PARITY_EN
            parity_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r         <= CNT_ZERO;
                    serial_out    <= 1'b1;
                    data_in_ready <= 1'b1;
                end
                START: begin
                    if (bit_wrap_s) begin
                        cnt_r      <= CNT_ZERO;
                        state_r    <= DATA;
                        bit_idx_r  <= 3'd0;
                        serial_out <= shift_r[0];
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_wrap_s) begin
                        cnt_r <= CNT_ZERO;
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_r    <= PARITY;
                            serial_out <= parity_r;
`else
                            state_r    <= STOP;
                            serial_out <= 1'b1;
`endif
                        end else begin
                            bit_idx_r  <= bit_idx_r + 3'd1;
                            serial_out <= shift_r[1];
                            shift_r    <= {1'b0, shift_r[7:1]};
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (bit_wrap_s) begin
                        cnt_r      <= CNT_ZERO;
                        state_r    <= STOP;
                        serial_out <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (bit_wrap_s) begin
                        cnt_r         <= CNT_ZERO;
                        state_r       <= IDLE;
                        serial_out    <= 1'b1;
                        data_in_ready <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == CNT_READY) begin
                            data_in_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    cnt_r         <= CNT_ZERO;
                    serial_out    <= 1'b1;
                    data_in_ready <= 1'b1;
                end
            endcase

            // A handshake can only happen in IDLE or on the final stop edge; it starts a new frame.
            if (accept_s) begin
                state_r       <= START;
                serial_out    <= 1'b0;
                data_in_ready <= 1'b0;
                cnt_r         <= CNT_ZERO;
                bit_idx_r     <= 3'd0;
                shift_r       <= data_in;
`ifdef UART_PARITY_EN
                parity_r      <= even_parity(data_in);
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a line monitor decodes frames into a queue that
// the scenario tasks compare against bytes queued when each handshake happens.
module tb_uart_transmitter;
    localparam int SPB = 10;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * SPB;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par;
        logic       stable;
        int         start;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         exp_start_q[$];
    frame_t     rx_q[$];

    uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out(serial_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: captures FRAME samples from each start bit and decodes them.
    logic [FRAME-1:0] mon_s;
    int     mon_n = 0;
    bit     mon_active = 1'b0;
    int     mon_start = 0;
    frame_t mon_f;
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
            mon_n = 0;
        end else if (!mon_active) begin
            if (serial_out === 1'b0) begin
                mon_active = 1'b1;
                mon_start = cyc;
                mon_s[0] = 1'b0;
                mon_n = 1;
            end
        end else begin
            mon_s[mon_n] = serial_out;
            mon_n++;
            if (mon_n == FRAME) begin
                mon_f.stable = 1'b1;
                for (int k = 0; k < NB; k++)
                    for (int j = 0; j < SPB; j++)
                        if (mon_s[k*SPB+j] !== mon_s[k*SPB]) mon_f.stable = 1'b0;
                for (int k = 0; k < 8; k++) mon_f.data[k] = mon_s[(k+1)*SPB];
                mon_f.par = mon_s[9*SPB];
                mon_f.stop = mon_s[(NB-1)*SPB];
                mon_f.start = mon_start;
                rx_q.push_back(mon_f);
                mon_active = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Presents a byte and waits for the handshake; returns one cycle after the accepting edge.
    task automatic send_byte(input logic [7:0] b, output int acc, output bit ok);
        data_in = b;
        data_in_valid = 1'b1;
        ok = 1'b0;
        acc = -1;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (data_in_ready === 1'b1) begin
                ok = 1'b1;
                acc = cyc;
                exp_q.push_back(b);
                exp_start_q.push_back(cyc + 1);
            end
            tick();
        end
    endtask

    task automatic get_frame(output frame_t f, output logic [7:0] eb, output int es, output bit ok);
        ok = 1'b0;
        eb = 8'h00;
        es = -1;
        f = '{data: 8'h00, stop: 1'b0, par: 1'b0, stable: 1'b0, start: -1};
        for (int i = 0; i < 400 && rx_q.size() == 0; i++) tick();
        if (rx_q.size() > 0 && exp_q.size() > 0) begin
            f = rx_q.pop_front();
            eb = exp_q.pop_front();
            es = exp_start_q.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        n_checks++;
        if ({serial_out, data_in_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_state: got line/ready=%b%b, expected 11", serial_out, data_in_ready);
        end
        bad = 0;
        repeat (20) begin
            tick();
            if ({serial_out, data_in_ready} !== 2'b11) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_idle: %0d non-idle cycles, expected 0", bad);
        end
    endtask

    task automatic test_single();
        int acc, cnt, es;
        bit ok;
        frame_t f;
        logic [7:0] eb;
        send_byte(8'hA5, acc, ok);
        data_in_valid = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_accept: no handshake, expected one"); end
        cnt = 0;
        while (data_in_ready !== 1'b1 && cnt < 300) begin cnt++; tick(); end
        n_checks++;
        if (cnt !== FRAME - 1) begin
            n_fail++;
            $display("FAIL single_ready_low: %0d cycles, expected %0d", cnt, FRAME - 1);
        end
        get_frame(f, eb, es, ok);
        n_checks++;
        if (!ok || {f.data, f.stop, f.stable} !== {8'hA5, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_frame: data=%h stop=%b stable=%b, expected a5 1 1", f.data, f.stop, f.stable);
        end
        n_checks++;
        if (f.start !== es) begin
            n_fail++;
            $display("FAIL single_latency: start cycle %0d, expected %0d", f.start, es);
        end
    endtask

    task automatic test_back_to_back();
        int a0, a1, es;
        bit ok0, ok1, ok;
        frame_t f;
        logic [7:0] eb;
        send_byte(8'h00, a0, ok0);
        send_byte(8'hFF, a1, ok1);
        data_in_valid = 1'b0;
        n_checks++;
        if (!(ok0 && ok1) || a1 - a0 !== FRAME) begin
            n_fail++;
            $display("FAIL b2b_accept_gap: %0d cycles, expected %0d", a1 - a0, FRAME);
        end
        for (int k = 0; k < 2; k++) begin
            get_frame(f, eb, es, ok);
            n_checks++;
            if (!ok || {f.data, f.stop, f.stable, f.start} !== {eb, 1'b1, 1'b1, es}) begin
                n_fail++;
                $display("FAIL b2b_frame%0d: data=%h stop=%b stable=%b start=%0d, expected %h 1 1 %0d",
                         k, f.data, f.stop, f.stable, f.start, eb, es);
            end
        end
    endtask

    task automatic test_ignore_change();
        int a0, a1, es;
        bit ok0, ok1, ok;
        frame_t f;
        logic [7:0] eb;
        send_byte(8'h5A, a0, ok0);
        data_in_valid = 1'b0;
        while (cyc < a0 + 30) tick();
        n_checks++;
        if (data_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_ready_busy: got %b, expected 0", data_in_ready);
        end
        send_byte(8'h3C, a1, ok1);
        data_in_valid = 1'b0;
        n_checks++;
        if (!(ok0 && ok1) || a1 - a0 !== FRAME) begin
            n_fail++;
            $display("FAIL ignore_second_accept: after %0d cycles, expected %0d", a1 - a0, FRAME);
        end
        for (int k = 0; k < 2; k++) begin
            get_frame(f, eb, es, ok);
            n_checks++;
            if (!ok || {f.data, f.stop, f.stable, f.start} !== {eb, 1'b1, 1'b1, es}) begin
                n_fail++;
                $display("FAIL ignore_frame%0d: data=%h stop=%b stable=%b start=%0d, expected %h 1 1 %0d",
                         k, f.data, f.stop, f.stable, f.start, eb, es);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int acc, es, bad;
        bit ok;
        frame_t f;
        logic [7:0] eb;
        send_byte(8'hFF, acc, ok);
        data_in_valid = 1'b0;
        while (cyc < acc + 35) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({serial_out, data_in_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL midreset_state: got line/ready=%b%b, expected 11", serial_out, data_in_ready);
        end
        void'(exp_q.pop_back());
        void'(exp_start_q.pop_back());
        bad = 0;
        repeat (FRAME + 10) begin
            tick();
            if (serial_out !== 1'b1) bad++;
        end
        n_checks++;
        if (bad !== 0 || rx_q.size() !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_resend: %0d low cycles, %0d frames, expected 0 0", bad, rx_q.size());
        end
        send_byte(8'h81, acc, ok);
        data_in_valid = 1'b0;
        get_frame(f, eb, es, ok);
        n_checks++;
        if (!ok || {f.data, f.stop, f.stable, f.start} !== {8'h81, 1'b1, 1'b1, es}) begin
            n_fail++;
            $display("FAIL midreset_clean: data=%h stop=%b stable=%b start=%0d, expected 81 1 1 %0d",
                     f.data, f.stop, f.stable, f.start, es);
        end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic [7:0] vals[2];
        int acc, es;
        bit ok;
        frame_t f;
        logic [7:0] eb;
        vals[0] = 8'h07;
        vals[1] = 8'h03;
        for (int k = 0; k < 2; k++) begin
            send_byte(vals[k], acc, ok);
            data_in_valid = 1'b0;
            get_frame(f, eb, es, ok);
            n_checks++;
            if (!ok || {f.data, f.par, f.stop, f.stable} !== {vals[k], ^vals[k], 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL parity_frame%0d: data=%h par=%b stop=%b stable=%b, expected %h %b 1 1",
                         k, f.data, f.par, f.stop, f.stable, vals[k], ^vals[k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_change();
        test_reset_mid_frame();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
